// File: rtl/cordic_rom_loader_if.sv
// Stream handshake carrying 16-bit CORDIC constant words into the ROM loader.
// The master drives the words; the slave (the loader) signals readiness.
interface cordic_rom_loader_if;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/cordic_rom_loader.sv
// Packs a 16-bit word stream into 64 x 48-bit hyperbolic CORDIC ROM entries, then steps the read index.
// Optional feature macro: CORDIC_ROM_CHECKSUM_EN adds a modulo-2^16 sum of all accepted words.
module cordic_rom_loader #(
    parameter int ENTRIES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    cordic_rom_loader_if.slave  stream,
    input  logic                step,
    output logic                wen,
    output logic                cen,
    output logic [5:0]          index_wri,
    output logic [5:0]          index_rea,
    output logic [47:0]         D,
    output logic                busy,
    output logic                load_done
`ifdef CORDIC_ROM_CHECKSUM_EN
   ,output logic [15:0]         checksum
`endif
);

    localparam logic [5:0] LAST_ENTRY = 6'(ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t     state;
    logic [5:0] entry_cnt;
    logic [1:0] word_cnt;
    logic       accept;
    logic       start_take;

    // din_ready is only ever high in FILL, so the handshake alone qualifies a word
    assign accept     = stream.din_valid && stream.din_ready;
    assign start_take = start && ((state == IDLE) || (state == RUN));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            entry_cnt        <= '0;
            word_cnt         <= '0;
            stream.din_ready <= 1'b0;
            wen              <= 1'b1;
            cen              <= 1'b1;
            index_wri        <= '0;
            index_rea        <= '0;
            D                <= '0;
            busy             <= 1'b0;
            load_done        <= 1'b0;
        end else if (start_take) begin
            // start outranks step when both arrive in RUN
            state            <= FILL;
            entry_cnt        <= '0;
            word_cnt         <= '0;
            D                <= '0;
            stream.din_ready <= 1'b1;
            wen              <= 1'b1;
            cen              <= 1'b1;
            index_rea        <= '0;
            busy             <= 1'b1;
            load_done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                end

                FILL: begin
                    if (accept) begin
                        unique case (word_cnt)
                            2'd0:    D[47:32] <= stream.din;
                            2'd1:    D[31:16] <= stream.din;
                            default: D[15:0]  <= stream.din;
                        endcase
                        if (word_cnt == 2'd2) begin
                            state            <= WRITE;
                            stream.din_ready <= 1'b0;
                            wen              <= 1'b0;
                            cen              <= 1'b0;
                            index_wri        <= entry_cnt;
                        end else begin
                            word_cnt <= word_cnt + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    wen <= 1'b1;
                    if (entry_cnt == LAST_ENTRY) begin
                        // cen stays asserted: the ROM is read from here on
                        state     <= RUN;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                        index_rea <= '0;
                    end else begin
                        state            <= FILL;
                        entry_cnt        <= entry_cnt + 6'd1;
                        word_cnt         <= '0;
                        cen              <= 1'b1;
                        stream.din_ready <= 1'b1;
                    end
                end

                RUN: begin
                    if (step) begin
                        index_rea <= index_rea + 6'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CORDIC_ROM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum <= '0;
        end else if (start_take) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + stream.din;
        end
    end
`else
    // build without the checksum datapath
`endif

endmodule

// File: tb/tb_cordic_rom_loader.sv
// Randomized self-checking bench for cordic_rom_loader against a queue-based packing model.
module tb_cordic_rom_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        wen;
    logic        cen;
    logic [5:0]  index_wri;
    logic [5:0]  index_rea;
    logic [47:0] D;
    logic        busy;
    logic        load_done;
`ifdef CORDIC_ROM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    cordic_rom_loader_if sif ();

    cordic_rom_loader #(.ENTRIES(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stream    (sif),
        .step      (step),
        .wen       (wen),
        .cen       (cen),
        .index_wri (index_wri),
        .index_rea (index_rea),
        .D         (D),
        .busy      (busy),
        .load_done (load_done)
`ifdef CORDIC_ROM_CHECKSUM_EN
       ,.checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] acc_q[$];
    int          exp_entry;
    logic [15:0] sum_model;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wen"},       wen,           48'd1);
        chk({tag, "_cen"},       cen,           48'd1);
        chk({tag, "_din_ready"}, sif.din_ready, 48'd0);
        chk({tag, "_busy"},      busy,          48'd0);
        chk({tag, "_load_done"}, load_done,     48'd0);
        chk({tag, "_index_wri"}, index_wri,     48'd0);
        chk({tag, "_index_rea"}, index_rea,     48'd0);
        chk({tag, "_D"},         D,             48'd0);
`ifdef CORDIC_ROM_CHECKSUM_EN
        chk({tag, "_checksum"},  checksum,      48'd0);
`endif
    endtask

    // pat: 0 sequential words, 1 sequential with 5-cycle stall in entry 10,
    //      2 random words and random valid, 3 start pulse mid-FILL, 4 reset during entry 30
    task automatic do_load(input int pat, input bit send_start);
        int          word_idx = 0;
        int          stall_left = 5;
        int          first_acc = -1;
        int          cyc = 0;
        bit          done = 0;
        bit          injected = 0;
        bit          v;
        bit          start_now;
        logic [15:0] d;
        logic [47:0] exp_d;

        acc_q.delete();
        exp_entry = 0;
        sum_model = '0;
        if (send_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("start_busy", busy, 48'd1);
            chk("start_ready", sif.din_ready, 48'd1);
        end

        while (!done && cyc < 2000) begin
            start_now = 0;
            if (pat == 4 && word_idx == 91) begin
                reset = 1'b0;
                sif.din_valid = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                check_reset_outputs("mid_rst");
                return;
            end
            if (pat == 2) begin
                v = ($urandom_range(0, 3) != 0);
                d = 16'($urandom);
            end else begin
                v = 1'b1;
                d = 16'(word_idx);
                if (pat == 1 && word_idx == 32 && stall_left > 0) begin
                    v = 1'b0;
                    stall_left--;
                end
            end
            if (pat == 3 && word_idx == 16 && !injected) begin
                injected = 1;
                start_now = 1;
            end
            start = start_now;
            sif.din_valid = v;
            sif.din = d;
            if (v && sif.din_ready) begin
                if (first_acc < 0) first_acc = cyc;
                acc_q.push_back(d);
                sum_model = sum_model + d;
                word_idx++;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (start_now) chk("fill_start_ignored_busy", busy, 48'd1);
            if (!wen) begin
                if (acc_q.size() < 3) begin
                    chk("write_without_3_words", 48'(acc_q.size()), 48'd3);
                end else begin
                    exp_d = {acc_q[0], acc_q[1], acc_q[2]};
                    repeat (3) void'(acc_q.pop_front());
                    chk("wr_addr", index_wri, 48'(exp_entry));
                    chk("wr_data", D, exp_d);
                    chk("wr_cen", cen, 48'd0);
                    exp_entry++;
                end
            end
            if (load_done) done = 1;
        end
        sif.din_valid = 1'b0;

        if (!done) begin
            chk("load_timeout", 48'd0, 48'd1);
        end else begin
            chk("entries_written", 48'(exp_entry), 48'd64);
            chk("words_left", 48'(acc_q.size()), 48'd0);
            if (pat == 0) chk("load_cycles", 48'(cyc - first_acc), 48'd256);
            if (pat == 1) chk("load_cycles_stall", 48'(cyc - first_acc), 48'd261);
            chk("run_busy", busy, 48'd0);
            chk("run_ready", sif.din_ready, 48'd0);
            chk("run_wen", wen, 48'd1);
            chk("run_cen", cen, 48'd0);
            chk("run_index_rea", index_rea, 48'd0);
`ifdef CORDIC_ROM_CHECKSUM_EN
            if (pat == 0) chk("checksum_seq", checksum, 48'h47A0);
            else chk("checksum", checksum, 48'(sum_model));
`endif
        end
    endtask

    task automatic step_test();
        int exp_idx = 0;
        for (int i = 0; i < 65; i++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            exp_idx = (exp_idx + 1) % 64;
            chk("step_idx", index_rea, 48'(exp_idx));
            if ($urandom_range(0, 1) != 0) begin
                @(negedge clk);
                chk("step_hold", index_rea, 48'(exp_idx));
            end
        end
        chk("step_final", index_rea, 48'd1);
        start = 1'b1;
        step = 1'b1;
        @(negedge clk);
        start = 1'b0;
        step = 1'b0;
        chk("start_step_idx", index_rea, 48'd0);
        chk("start_step_busy", busy, 48'd1);
        chk("start_step_done", load_done, 48'd0);
        chk("start_step_ready", sif.din_ready, 48'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.din_valid = 1'b0;
        sif.din = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("idle_step_ignored", index_rea, 48'd0);
        chk("idle_ready", sif.din_ready, 48'd0);
        chk("idle_cen", cen, 48'd1);

        do_load(0, 1'b1);
        step_test();
        do_load(2, 1'b0);
        do_load(1, 1'b1);
        do_load(3, 1'b1);
        do_load(4, 1'b1);
        do_load(0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cordic_rom_loader.md
# cordic_rom_loader

Loads the 64-entry × 48-bit hyperbolic CORDIC constant table into the ROM stage. Constants arrive as a stream of 16-bit words over a valid/ready handshake, are packed three at a time into one 48-bit entry, and are written into consecutive addresses. After all 64 entries are written, the block switches to run mode and generates the read index that steps the table during CORDIC iterations.

## Interface
Parameters:
- ENTRIES, 64, number of table entries written per load; fixed to the 6-bit address space.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a table load.
- din  input  16  constant word.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block accepts din this cycle.
- step  input  1  in RUN, advance index_rea by one.
- wen  output  1  ROM write enable, active-low (0 = write).
- cen  output  1  ROM chip enable, active-low.
- index_wri  output  6  ROM write address.
- index_rea  output  6  ROM read address.
- D  output  48  ROM write data.
- busy  output  1  load in progress (FILL or WRITE).
- load_done  output  1  table fully loaded (RUN).
- checksum  output  16  present only with CORDIC_ROM_CHECKSUM_EN.

## Operation
- States: IDLE, FILL, WRITE, RUN.
- IDLE: din_ready=0, wen=1, cen=1. start=1 -> FILL; clear entry counter, word counter, and D.
- FILL: din_ready=1. A word is accepted when din_valid && din_ready.
  - Word 0 -> D[47:32], word 1 -> D[31:16], word 2 -> D[15:0].
  - Accepting word 2 -> WRITE.
- WRITE: lasts exactly one cycle. wen=0, cen=0, din_ready=0, index_wri=entry counter, D=packed entry.
  - If entry counter = 63: -> RUN.
  - Otherwise: increment entry counter, clear word counter, -> FILL.
- RUN: load_done=1, cen=0, wen=1, din_ready=0.
  - index_rea is 0 on RUN entry.
  - step=1 increments index_rea, wrapping 63 -> 0.
  - start=1 -> FILL with all counters cleared; start has priority over step in the same cycle.
- start in FILL or WRITE is ignored.
- step outside RUN is ignored.
- index_rea is held at 0 outside RUN. index_wri holds its last value outside WRITE.
- Reset, including mid-load: state=IDLE, wen=1, cen=1, din_ready=0, busy=0, load_done=0, index_wri=0, index_rea=0, D=0, checksum=0. A partially loaded table is not valid; a new start is required.

## Timing
- start sampled in IDLE -> FILL, din_ready=1 on the next cycle.
- With din_valid held high, each entry takes 4 cycles (3 accepts + 1 write). A full load is 256 cycles from the first accept to RUN entry.
- load_done rises on the cycle after the write of entry 63.
- din_valid low in FILL stalls the load with no loss of state.
- All outputs are registered.
- index_rea changes on the cycle after step. The ROM read is asynchronous, so Q follows in the same cycle as the index_rea change.

## Configuration
- CORDIC_ROM_CHECKSUM_EN defined:
  - checksum port exists.
  - checksum is cleared on an accepted start.
  - Every accepted din word is added modulo 2^16.
  - checksum holds its value in RUN and IDLE, and is valid when load_done=1.
- CORDIC_ROM_CHECKSUM_EN undefined: no checksum port and no adder logic. All other behaviour is identical.

## Test plan
- Reset, then start; stream words 0x0000..0x00BF with din_valid always high -> 64 writes; entry k has D = {3k, 3k+1, 3k+2} and index_wri=k; load_done=1 exactly 256 cycles after the first accept.
- Deassert din_valid for 5 cycles after word 1 of entry 10 -> stall with no extra write; entry 10 packed correctly; total load takes 261 cycles.
- In RUN, issue 65 step pulses -> index_rea counts 1..63, 0, 1; start and step in the same cycle -> FILL, index_rea=0.
- Pulse reset low during entry 30 -> all outputs return to reset values next cycle; a following start restarts at index_wri=0.
- start pulse during FILL -> ignored; word and entry counters unchanged.
- With CORDIC_ROM_CHECKSUM_EN and words 0x0000..0x00BF -> checksum = 0x47A0 at load_done.
